// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request bundle and HI/LO/busy results
// for the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        exc_int;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start,
        output op,
        output A,
        output B,
        output exc_int,
        input  busy,
        input  HI,
        input  LO
    );

    modport slave (
        input  start,
        input  op,
        input  A,
        input  B,
        input  exc_int,
        output busy,
        output HI,
        output LO
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/multu/div/divu with architectural
// HI/LO; results are computed at accept and committed at the end.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    md_unit_if.slave md
);

    localparam int MAXC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CW-1:0] CNT_MUL = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hi_t_q, hi_t_d;
    logic [31:0]   lo_t_q, lo_t_d;
    logic          dz_q, dz_d;

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic sgn;
    logic accept;

    // Decode the op field into one-hot class flags.
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        sgn     = 1'b0;
        unique case (1'b1)
            (md.op == OP_MULT): begin
                is_mul = 1'b1;
                sgn    = 1'b1;
            end
            (md.op == OP_MULTU): begin
                is_mul = 1'b1;
            end
            (md.op == OP_DIV): begin
                is_div = 1'b1;
                sgn    = 1'b1;
            end
            (md.op == OP_DIVU): begin
                is_div = 1'b1;
            end
            (md.op == OP_MTHI): begin
                is_mthi = 1'b1;
            end
            (md.op == OP_MTLO): begin
                is_mtlo = 1'b1;
            end
            default: ;
        endcase
    end

    // A cancelled or busy-time request never touches any state.
    assign accept = md.start
                  & ~md.exc_int
                  & (state_q == IDLE)
                  & (is_mul | is_div | is_mthi | is_mtlo);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    // Sign/zero extension makes one 64-bit multiply serve both forms.
    always_comb begin
        a_ext = sgn ? {{32{md.A[31]}}, md.A} : {32'd0, md.A};
        b_ext = sgn ? {{32{md.B[31]}}, md.B} : {32'd0, md.B};
        prod  = a_ext * b_ext;
    end

    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Divide on magnitudes, then restore signs: quotient truncates
    // toward zero, remainder follows the dividend.
    always_comb begin
        a_neg  = sgn & md.A[31];
        b_neg  = sgn & md.B[31];
        b_zero = (md.B == 32'd0);
        a_mag  = a_neg ? (32'd0 - md.A) : md.A;
        b_mag  = b_neg ? (32'd0 - md.B) : md.B;
        b_safe = b_zero ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Next-state logic: accept in IDLE, count down and commit in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_t_d  = hi_t_q;
        lo_t_d  = lo_t_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        is_mul: begin
                            hi_t_d  = prod[63:32];
                            lo_t_d  = prod[31:0];
                            dz_d    = 1'b0;
                            cnt_d   = CNT_MUL;
                            state_d = RUN;
                        end
                        is_div: begin
                            hi_t_d  = rem;
                            lo_t_d  = quo;
                            dz_d    = b_zero;
                            cnt_d   = CNT_DIV;
                            state_d = RUN;
                        end
                        is_mthi: begin
                            hi_d = md.A;
                        end
                        is_mtlo: begin
                            lo_d = md.A;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = hi_t_q;
                        lo_d = lo_t_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and HI/LO registers; reset wins over any running op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_t_q  <= '0;
            lo_t_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_t_q  <= hi_t_d;
            lo_t_q  <= lo_t_d;
            dz_q    <= dz_d;
        end
    end

    assign md.busy = (state_q == RUN);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit, checked every cycle
// against an arithmetic model plus literal result checks.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    bit   chk_en;

    md_unit_if md ();

    md_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          m_rem;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    bit          p_ok;

    // Reference model: plain integer arithmetic on the ISA rules.
    always @(posedge clk) begin : model
        longint          ps;
        longint unsigned pu;
        int              sq;
        int              sr;
        if (reset) begin
            m_rem <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && p_ok) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (md.start && !md.exc_int) begin
            case (md.op)
                3'd1: begin
                    ps = longint'($signed(md.A))
                       * longint'($signed(md.B));
                    p_hi  <= ps[63:32];
                    p_lo  <= ps[31:0];
                    p_ok  <= 1'b1;
                    m_rem <= MC;
                end
                3'd2: begin
                    pu = {32'd0, md.A} * {32'd0, md.B};
                    p_hi  <= pu[63:32];
                    p_lo  <= pu[31:0];
                    p_ok  <= 1'b1;
                    m_rem <= MC;
                end
                3'd3: begin
                    if (md.B != 0) begin
                        sq = $signed(md.A) / $signed(md.B);
                        sr = $signed(md.A) % $signed(md.B);
                        p_hi <= sr;
                        p_lo <= sq;
                        p_ok <= 1'b1;
                    end else begin
                        p_ok <= 1'b0;
                    end
                    m_rem <= DC;
                end
                3'd4: begin
                    if (md.B != 0) begin
                        p_hi <= md.A % md.B;
                        p_lo <= md.A / md.B;
                        p_ok <= 1'b1;
                    end else begin
                        p_ok <= 1'b0;
                    end
                    m_rem <= DC;
                end
                3'd5: m_hi <= md.A;
                3'd6: m_lo <= md.A;
                default: ;
            endcase
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", {31'd0, md.busy},
                {31'd0, m_rem > 0});
            chk("cyc_HI", md.HI, m_hi);
            chk("cyc_LO", md.LO, m_lo);
        end
    end

    task automatic issue(input logic [2:0]  op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic        exc);
        @(posedge clk);
        #1;
        md.start   = 1'b1;
        md.op      = op;
        md.A       = a;
        md.B       = b;
        md.exc_int = exc;
        @(posedge clk);
        #1;
        md.start   = 1'b0;
        md.op      = 3'd0;
        md.exc_int = 1'b0;
    endtask

    task automatic run_to_idle(output int n);
        n = 0;
        while (md.busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: still busy after %0d", n);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        n_tests    = 0;
        n_fail     = 0;
        chk_en     = 1'b0;
        reset      = 1'b1;
        md.start   = 1'b0;
        md.op      = 3'd0;
        md.A       = '0;
        md.B       = '0;
        md.exc_int = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, md.busy}, 32'd0);
        chk("rst_HI", md.HI, 32'h0);
        chk("rst_LO", md.LO, 32'h0);

        issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_to_idle(n);
        chk("mult_cycles", n, MC);
        chk("mult_HI", md.HI, 32'hFFFFFFFF);
        chk("mult_LO", md.LO, 32'hFFFFFFFE);

        issue(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        md.start = 1'b1;
        md.op    = 3'd1;
        md.A     = 32'd3;
        md.B     = 32'd3;
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.op    = 3'd0;
        run_to_idle(n);
        chk("multu_rest", n, MC - 2);
        chk("multu_HI", md.HI, 32'h00000001);
        chk("multu_LO", md.LO, 32'hFFFFFFFE);

        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_to_idle(n);
        chk("div_cycles", n, DC);
        chk("div_LO", md.LO, 32'hFFFFFFFD);
        chk("div_HI", md.HI, 32'hFFFFFFFF);

        issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_to_idle(n);
        chk("divu_LO", md.LO, 32'h7FFFFFFC);
        chk("divu_HI", md.HI, 32'h00000001);

        @(posedge clk);
        #1;
        md.start = 1'b1;
        md.op    = 3'd5;
        md.A     = 32'h12345678;
        @(posedge clk);
        #1;
        md.op    = 3'd6;
        md.A     = 32'h9ABCDEF0;
        #2;
        chk("mthi_HI", md.HI, 32'h12345678);
        chk("mthi_busy", {31'd0, md.busy}, 32'd0);
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.op    = 3'd0;
        #2;
        chk("mtlo_LO", md.LO, 32'h9ABCDEF0);
        chk("mtlo_busy", {31'd0, md.busy}, 32'd0);

        issue(3'd3, 32'd55, 32'd0, 1'b0);
        run_to_idle(n);
        chk("dz_cycles", n, DC);
        chk("dz_HI", md.HI, 32'h12345678);
        chk("dz_LO", md.LO, 32'h9ABCDEF0);

        issue(3'd1, 32'd7, 32'd9, 1'b1);
        chk("exc_busy", {31'd0, md.busy}, 32'd0);
        issue(3'd5, 32'hDEADBEEF, 32'd0, 1'b1);
        chk("exc_HI", md.HI, 32'h12345678);
        issue(3'd7, 32'd1, 32'd1, 1'b0);
        chk("rsv_busy", {31'd0, md.busy}, 32'd0);
        chk("rsv_LO", md.LO, 32'h9ABCDEF0);

        issue(3'd1, 32'd3, 32'hFFFFFFFC, 1'b0);
        @(posedge clk);
        #1;
        md.exc_int = 1'b1;
        @(posedge clk);
        #1;
        md.exc_int = 1'b0;
        run_to_idle(n);
        chk("excrun_rest", n, MC - 2);
        chk("excrun_HI", md.HI, 32'hFFFFFFFF);
        chk("excrun_LO", md.LO, 32'hFFFFFFF4);

        issue(3'd3, 32'd100, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mrst_busy", {31'd0, md.busy}, 32'd0);
        chk("mrst_HI", md.HI, 32'h0);
        chk("mrst_LO", md.LO, 32'h0);

        issue(3'd1, 32'h00010000, 32'h00010000, 1'b0);
        run_to_idle(n);
        chk("post_cycles", n, MC);
        chk("post_HI", md.HI, 32'h00000001);
        chk("post_LO", md.LO, 32'h00000000);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
